// File: rtl/sram_burst_ctrl_pkg.sv
// sram_burst_pkg: shared widths, FSM encoding and read-buffer depth
// for the SRAM burst controller. No ports.
package sram_burst_pkg;
    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 15;
    localparam int LEN_SIZE = 8;
    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;
endpackage

// File: rtl/sram_burst_ctrl_if.sv
// sram_burst_ctrl_if: command, write-data, read-data and SRAM port bundle.
// master = DMA/bridge + SRAM side, slave = burst controller.
interface sram_burst_ctrl_if #(
    parameter int DATA_SIZE = sram_burst_pkg::DATA_SIZE,
    parameter int ADDR_SIZE = sram_burst_pkg::ADDR_SIZE,
    parameter int LEN_SIZE  = sram_burst_pkg::LEN_SIZE
);
    logic                 in_cmd_valid;
    logic                 out_cmd_ready;
    logic                 in_cmd_write;
    logic [ADDR_SIZE-1:0] in_cmd_addr;
    logic [LEN_SIZE-1:0]  in_cmd_len;
    logic                 in_wdata_valid;
    logic                 out_wdata_ready;
    logic [DATA_SIZE-1:0] in_wdata;
    logic                 out_rdata_valid;
    logic                 in_rdata_ready;
    logic [DATA_SIZE-1:0] out_rdata;
    logic                 out_rdata_last;
    logic                 out_busy;
    logic                 out_sram_write_en;
    logic [ADDR_SIZE-1:0] out_sram_write_addr;
    logic [DATA_SIZE-1:0] out_sram_write_data;
    logic                 out_sram_read_en;
    logic [ADDR_SIZE-1:0] out_sram_read_addr;
    logic [DATA_SIZE-1:0] in_sram_read_data;

    modport master (
        output in_cmd_valid, in_cmd_write, in_cmd_addr, in_cmd_len,
        output in_wdata_valid, in_wdata, in_rdata_ready,
        output in_sram_read_data,
        input  out_cmd_ready, out_wdata_ready, out_rdata_valid,
        input  out_rdata, out_rdata_last, out_busy,
        input  out_sram_write_en, out_sram_write_addr,
        input  out_sram_write_data, out_sram_read_en,
        input  out_sram_read_addr
    );

    modport slave (
        input  in_cmd_valid, in_cmd_write, in_cmd_addr, in_cmd_len,
        input  in_wdata_valid, in_wdata, in_rdata_ready,
        input  in_sram_read_data,
        output out_cmd_ready, out_wdata_ready, out_rdata_valid,
        output out_rdata, out_rdata_last, out_busy,
        output out_sram_write_en, out_sram_write_addr,
        output out_sram_write_data, out_sram_read_en,
        output out_sram_read_addr
    );
endinterface

// File: rtl/sram_burst_ctrl_rd_skid.sv
// sram_rd_skid: 2-entry FIFO of {data,last} for the read return path.
// Ports: clk, rst (sync high), push/din, pop/dout, full, empty, count.
module sram_rd_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);
    import sram_burst_pkg::*;

    logic [WIDTH-1:0] mem [RD_BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'(RD_BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst initiator moving valid/ready streams to/from SRAM.
// Ports: in_clk, in_rst (sync high), bus (slave: cmd, wdata, rdata, SRAM).
// Optional SRAM_BURST_CTRL_STATS_EN adds out_stat_wr_beats/out_stat_rd_beats.
module sram_burst_ctrl #(
    parameter int DATA_SIZE = sram_burst_pkg::DATA_SIZE,
    parameter int ADDR_SIZE = sram_burst_pkg::ADDR_SIZE,
    parameter int LEN_SIZE  = sram_burst_pkg::LEN_SIZE
) (
    input  logic               in_clk,
    input  logic               in_rst,
    sram_burst_ctrl_if.slave   bus
`ifdef SRAM_BURST_CTRL_STATS_EN
    ,
    output logic [31:0]        out_stat_wr_beats,
    output logic [31:0]        out_stat_rd_beats
`endif
);
    import sram_burst_pkg::*;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam logic [1:0] S_READ  = READ;

    logic [1:0]           state;
    logic [ADDR_SIZE-1:0] addr;
    logic [LEN_SIZE-1:0]  beats_left;
    logic                 is_last;
    logic                 cmd_hs;
    logic                 wr_hs;
    logic                 rd_issue;
    logic                 rd_pop;
    logic                 buf_full;
    logic                 buf_empty;
    logic [1:0]           buf_count;
    logic [DATA_SIZE:0]   buf_dout;

    assign is_last = (beats_left == '0);
    assign cmd_hs  = bus.in_cmd_valid && bus.out_cmd_ready;
    assign wr_hs   = bus.in_wdata_valid && bus.out_wdata_ready;
    assign rd_pop  = bus.out_rdata_valid && bus.in_rdata_ready;
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    assign rd_issue = (state == S_READ) && !in_rst && (!buf_full || rd_pop);

    // Outputs are gated by reset so nothing is issued in the reset cycle.
    assign bus.out_cmd_ready   = (state == S_IDLE) && (buf_count == 2'd0)
                                 && !in_rst;
    assign bus.out_wdata_ready = (state == S_WRITE) && !in_rst;
    assign bus.out_rdata_valid = !buf_empty && !in_rst;
    assign bus.out_rdata       = buf_dout[DATA_SIZE:1];
    assign bus.out_rdata_last  = buf_dout[0];
    assign bus.out_busy        = (state != S_IDLE) || (buf_count != 2'd0);

    assign bus.out_sram_write_en   = wr_hs;
    assign bus.out_sram_write_addr = wr_hs ? addr : '0;
    assign bus.out_sram_write_data = wr_hs ? bus.in_wdata : '0;
    assign bus.out_sram_read_en    = rd_issue;
    assign bus.out_sram_read_addr  = rd_issue ? addr : '0;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            beats_left <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        addr       <= bus.in_cmd_addr;
                        beats_left <= bus.in_cmd_len;
                        state      <= bus.in_cmd_write ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (wr_hs) begin
                        addr       <= addr + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (is_last) state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (rd_issue) begin
                        addr       <= addr + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (is_last) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sram_rd_skid #(
        .WIDTH(DATA_SIZE + 1)
    ) u_rd_buf (
        .clk   (in_clk),
        .rst   (in_rst),
        .push  (rd_issue),
        .pop   (rd_pop),
        .din   ({bus.in_sram_read_data, is_last}),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

`ifdef SRAM_BURST_CTRL_STATS_EN
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_stat_wr_beats <= '0;
            out_stat_rd_beats <= '0;
        end else begin
            if (wr_hs && (out_stat_wr_beats != '1))
                out_stat_wr_beats <= out_stat_wr_beats + 1'b1;
            if (rd_pop && (out_stat_rd_beats != '1))
                out_stat_rd_beats <= out_stat_rd_beats + 1'b1;
        end
    end
`endif
endmodule
